nibble_serial_adder: RTL

Multi-cycle wide-word adder controller built around a combinational 4-bit add slice with carry in/out. Accepts WIDTH-bit operands over a valid/ready handshake and feeds them LSB-nibble-first to the slice, one nibble per cycle. Carries the slice's carry-out in a register between cycles and assembles the full sum. Presents result and flags downstream over a second valid/ready handshake. Sits between the ALU operand register stage and the ALU result/flag register stage.

---
 rtl/alu_pkg.sv | 19 +
 rtl/nibble_add_slice.sv | 15 +
 rtl/nibble_serial_adder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: controller state encoding, slice width and the
// flag bundle handed to the ALU result/flag register stage.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit add slice with carry in/out, time-multiplexed by the
// serial adder controller.
module nibble_add_slice
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single add slice,
// LSB first. Define SERIAL_ADDER_SUB_EN to add the 'sub' port (A-B mode).
module nibble_serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg, sum_next;
  logic               carry_reg;
  alu_flags_t         flags;
  logic               sub_eff;
  logic [NIBBLE_W-1:0] slice_s;
  logic               slice_cout;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // Handshake signals come from the state alone, so no valid/ready loop forms.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    case (state)
      IDLE:    if (in_valid)     next_state = RUN;
      RUN:     if (count == LAST) next_state = DONE;
      DONE:    if (out_ready)    next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  nibble_add_slice u_slice (
    .x    (a_reg[count*NIBBLE_W +: NIBBLE_W]),
    .y    (b_reg[count*NIBBLE_W +: NIBBLE_W]),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Full sum as it will look after this cycle's nibble write; feeds zero/overflow.
  always_comb begin
    sum_next = sum_reg;
    sum_next[count*NIBBLE_W +: NIBBLE_W] = slice_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
      flags     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg     <= a;
          b_reg     <= sub_eff ? ~b : b;
          carry_reg <= sub_eff | carry_in;
          count     <= '0;
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= slice_cout;
          if (count == LAST) begin
            flags.carry    <= slice_cout;
            flags.overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                              (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
            flags.zero     <= (sum_next == '0);
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_reg;
  assign carry_out = flags.carry;
  assign overflow  = flags.overflow;
  assign zero      = flags.zero;

endmodule
